// File: rtl/chi_rxflit_buf.sv
// Credit-managed receive flit buffer for one CHI RX channel.
// Flits arrive under link-layer credit control; the host reads the head flit word by word and pops it.
module chi_rxflit_buf #(
  parameter int    FLIT_WIDTH = 128,
  parameter int    RWIDTH     = 32,
  parameter int    DEPTH_LOG2 = 4,
  parameter int    CREDITS    = 15,
  parameter string OREG       = "TRUE",
  localparam int   NW         = FLIT_WIDTH / RWIDTH,
  localparam int   WSEL       = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flit_valid,
  input  logic [FLIT_WIDTH-1:0] flit,
  output logic                  lcrd_v,
  input  logic                  rd_en,
  input  logic [WSEL-1:0]       rd_word,
  output logic [RWIDTH-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  pop,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  err_ovf,
  output logic                  err_udf,
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W:0] CRED_LIM = (CNT_W + 1)'(CREDITS);
  localparam bit USE_OREG = (OREG == "TRUE");

  // Word extraction; an index past the last word of the flit yields zero.
  function automatic logic [RWIDTH-1:0] word_sel(input logic [FLIT_WIDTH-1:0] f,
                                                 input logic [WSEL-1:0] idx);
    logic [RWIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < NW; i++)
      if (idx == WSEL'(i)) w = f[i*RWIDTH +: RWIDTH];
    return w;
  endfunction

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [CNT_W-1:0]      cred_out;
  logic                  accept;
  logic                  pop_ok;
  logic                  lcrd_next;
  logic                  vld_p1;
  logic [RWIDTH-1:0]     rd_data_p1;

  assign accept    = flit_valid && (cred_out != '0);
  assign pop_ok    = pop && (count != '0);
  // Stored flits still occupy their credit, so a slot is re-advertised only once popped.
  assign lcrd_next = ({1'b0, cred_out} + {1'b0, count}) < CRED_LIM;
  assign empty     = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      cred_out <= '0;
      lcrd_v   <= 1'b0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      lcrd_v <= lcrd_next;
      case ({lcrd_next, accept})
        2'b10:   cred_out <= cred_out + CNT_W'(1);
        2'b01:   cred_out <= cred_out - CNT_W'(1);
        default: cred_out <= cred_out;
      endcase
      case ({accept, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept) wptr <= wptr + DEPTH_LOG2'(1);
      if (pop_ok) rptr <= rptr + DEPTH_LOG2'(1);
      // A new error event in the same cycle as a clear keeps the flag set.
      err_ovf <= (err_ovf && !err_clr) || (flit_valid && (cred_out == '0));
      err_udf <= (err_udf && !err_clr) || ((pop || rd_en) && (count == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= flit;
  end

  // Stage p0 -> p1: sample the current head before any same-cycle pop takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rd_data_p1 <= (count != '0) ? word_sel(mem[rptr], rd_word) : '0;
    end
  end

  generate
    if (USE_OREG) begin : g_oreg
      logic              vld_p2;
      logic [RWIDTH-1:0] rd_data_p2;

      // Stage p1 -> p2: optional output register.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p2     <= 1'b0;
          rd_data_p2 <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) rd_data_p2 <= rd_data_p1;
        end
      end

      assign rd_valid = vld_p2;
      assign rd_data  = rd_data_p2;
    end else begin : g_noreg
      assign rd_valid = vld_p1;
      assign rd_data  = rd_data_p1;
    end
  endgenerate

endmodule

// File: tb/tb_chi_rxflit_buf.sv
// Randomized bench for chi_rxflit_buf with a queue-based reference model and a credit-counting transmitter.
module tb_chi_rxflit_buf;

  localparam int CREDITS = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         flit_valid;
  logic [127:0] flit;
  logic         lcrd_v;
  logic         rd_en;
  logic [1:0]   rd_word;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic         pop;
  logic [4:0]   count;
  logic         empty;
  logic         err_ovf;
  logic         err_udf;
  logic         err_clr;

  int total = 0;
  int bad   = 0;

  chi_rxflit_buf #(
    .FLIT_WIDTH(128), .RWIDTH(32), .DEPTH_LOG2(4), .CREDITS(CREDITS), .OREG("TRUE")
  ) dut (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit(flit), .lcrd_v(lcrd_v),
    .rd_en(rd_en), .rd_word(rd_word), .rd_data(rd_data), .rd_valid(rd_valid),
    .pop(pop), .count(count), .empty(empty), .err_ovf(err_ovf), .err_udf(err_udf),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: stored flits as a queue, transmitter-held credits as an integer,
  // and a two-deep read delay line.
  logic [127:0] q[$];
  int           mcred;
  logic         exp_lcrd, exp_ovf, exp_udf, exp_rdv;
  logic [31:0]  exp_rdata;
  logic         pv[2];
  logic [31:0]  pd[2];
  int           tx_cred;

  wire [9:0] act_status = {lcrd_v, rd_valid, count, empty, err_ovf, err_udf};

  function automatic logic [31:0] word_of(input logic [127:0] f, input int w);
    logic [127:0] s;
    s = f >> (32 * w);
    return s[31:0];
  endfunction

  function automatic logic [9:0] exp_status();
    return {exp_lcrd, exp_rdv, 5'(q.size()), (q.size() == 0), exp_ovf, exp_udf};
  endfunction

  task automatic step();
    logic lnext, acc, popok;
    if (rst) begin
      q.delete();
      mcred = 0; exp_lcrd = 0; exp_ovf = 0; exp_udf = 0; exp_rdv = 0;
      exp_rdata = '0; pv[0] = 0; pv[1] = 0; pd[0] = '0; pd[1] = '0; tx_cred = 0;
    end else begin
      lnext = (mcred + q.size()) < CREDITS;
      acc   = flit_valid && (mcred > 0);
      popok = pop && (q.size() > 0);
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = rd_en;
      if (rd_en) pd[0] = (q.size() > 0) ? word_of(q[0], int'(rd_word)) : 32'h0;
      exp_rdv = pv[1];
      if (pv[1]) exp_rdata = pd[1];
      exp_ovf = (exp_ovf && !err_clr) || (flit_valid && (mcred == 0));
      exp_udf = (exp_udf && !err_clr) || ((pop || rd_en) && (q.size() == 0));
      mcred   = mcred + int'(lnext) - int'(acc);
      if (acc) q.push_back(flit);
      if (popok) void'(q.pop_front());
      exp_lcrd = lnext;
      if (flit_valid && tx_cred > 0) tx_cred--;
    end
    @(posedge clk);
    #1;
    if (lcrd_v) tx_cred++;
  endtask

  task automatic idle_inputs();
    flit_valid = 0; pop = 0; rd_en = 0; err_clr = 0; rd_word = 0;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1; flit = '0; idle_inputs();
    step(); step();
    total++;
    if ({act_status, rd_data} !== {10'b0000000100, 32'h0}) begin
      bad++; $display("FAIL reset_state got=%b/%h exp=%b/%h", act_status, rd_data, 10'b0000000100, 32'h0);
    end
    rst = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (lcrd_v !== 1'(k <= CREDITS)) begin
        bad++; $display("FAIL reset_lcrd cycle=%0d got=%b exp=%b", k, lcrd_v, (k <= CREDITS));
      end
      if (lcrd_v) pulses++;
    end
    total++;
    if (pulses != CREDITS || empty !== 1'b1 || count !== 5'd0) begin
      bad++; $display("FAIL reset_credits pulses=%0d empty=%b count=%0d exp pulses=%0d empty=1 count=0", pulses, empty, count, CREDITS);
    end
  endtask

  task automatic test_read_words();
    logic [31:0] got[4];
    logic [31:0] want[4];
    int nv;
    want[0] = 32'h55667788; want[1] = 32'h11223344; want[2] = 32'h89ABCDEF; want[3] = 32'h01234567;
    flit = 128'h0123_4567_89AB_CDEF_1122_3344_5566_7788; flit_valid = 1;
    step();
    flit_valid = 0; nv = 0;
    for (int i = 0; i < 7; i++) begin
      rd_en = (i < 4); rd_word = 2'(i);
      step();
      total++;
      if (rd_valid !== 1'(i >= 1 && i <= 4)) begin
        bad++; $display("FAIL read_latency step=%0d got=%b exp=%b", i, rd_valid, (i >= 1 && i <= 4));
      end
      if (rd_valid && nv < 4) begin got[nv] = rd_data; nv++; end
    end
    for (int w = 0; w < 4; w++) begin
      total++;
      if (w >= nv || got[w] !== want[w]) begin
        bad++; $display("FAIL read_word%0d got=%h exp=%h", w, (w < nv) ? got[w] : 32'hx, want[w]);
      end
    end
    rd_en = 0; pop = 1;
    step();
    pop = 0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (act_status !== exp_status()) begin
      bad++; $display("FAIL read_pop_status got=%b exp=%b", act_status, exp_status());
    end
  endtask

  task automatic test_fill_credits();
    for (int i = 0; i < CREDITS; i++) begin
      flit = {$urandom, $urandom, $urandom, $urandom};
      flit_valid = (tx_cred > 0);
      step();
      total++;
      if (act_status !== exp_status()) begin
        bad++; $display("FAIL fill_status i=%0d got=%b exp=%b", i, act_status, exp_status());
      end
    end
    flit_valid = 0;
    total++;
    if (count !== 5'd15 || lcrd_v !== 1'b0) begin
      bad++; $display("FAIL fill_full count=%0d lcrd_v=%b exp count=15 lcrd_v=0", count, lcrd_v);
    end
    pop = 1; rd_en = 1; rd_word = 2'(1);
    step();
    pop = 0; rd_en = 0;
    total++;
    if (count !== 5'd14 || lcrd_v !== 1'b0) begin
      bad++; $display("FAIL fill_pop count=%0d lcrd_v=%b exp count=14 lcrd_v=0", count, lcrd_v);
    end
    step();
    total++;
    if (lcrd_v !== 1'b1) begin bad++; $display("FAIL fill_credit_return got=%b exp=1", lcrd_v); end
    step();
    total++;
    if (act_status !== exp_status() || rd_data !== exp_rdata) begin
      bad++; $display("FAIL fill_pop_read got=%b/%h exp=%b/%h", act_status, rd_data, exp_status(), exp_rdata);
    end
  endtask

  task automatic test_overflow();
    flit = {$urandom, $urandom, $urandom, $urandom}; flit_valid = 1;
    step();
    total++;
    if (count !== 5'd15 || err_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_last_credit count=%0d err_ovf=%b exp 15/0", count, err_ovf);
    end
    flit = {$urandom, $urandom, $urandom, $urandom}; flit_valid = 1;
    step();
    total++;
    if (count !== 5'd15 || err_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_drop count=%0d err_ovf=%b exp 15/1", count, err_ovf);
    end
    flit_valid = 0; err_clr = 1;
    step();
    total++;
    if (err_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", err_ovf); end
    flit_valid = 1;
    step();
    total++;
    if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_clear_vs_event got=%b exp=1", err_ovf); end
    flit_valid = 0;
    step();
    err_clr = 0;
    for (int i = 0; i < 35; i++) begin
      pop = (i < 15); rd_en = (i < 15); rd_word = 2'($urandom_range(0, 3));
      step();
      total++;
      if (act_status !== exp_status() || (exp_rdv && rd_data !== exp_rdata)) begin
        bad++; $display("FAIL ovf_drain i=%0d got=%b/%h exp=%b/%h", i, act_status, rd_data, exp_status(), exp_rdata);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 144; i++) begin
      flit = {$urandom, $urandom, $urandom, $urandom};
      rd_word = 2'($urandom_range(0, 3));
      err_clr = 0;
      if (i < 4) begin
        flit_valid = 1; pop = 0; rd_en = 0;
      end else if (i < 44) begin
        flit_valid = (tx_cred > 0); pop = 1; rd_en = 1;
      end else if (i < 104) begin
        flit_valid = (tx_cred > 0) && ($urandom_range(0, 1) == 1);
        pop = ($urandom_range(0, 1) == 1); rd_en = ($urandom_range(0, 1) == 1);
        err_clr = ($urandom_range(0, 7) == 0);
      end else begin
        flit_valid = 0; pop = (q.size() > 0); rd_en = pop;
      end
      step();
      total++;
      if (act_status !== exp_status() || (exp_rdv && rd_data !== exp_rdata)) begin
        bad++; $display("FAIL stream i=%0d got=%b/%h exp=%b/%h", i, act_status, rd_data, exp_status(), exp_rdata);
      end
    end
    idle_inputs();
  endtask

  task automatic test_underflow_reset();
    logic [127:0] f;
    int pulses;
    err_clr = 1;
    step();
    err_clr = 0; pop = 1; rd_en = 1; rd_word = 2'(2);
    step();
    pop = 0; rd_en = 0;
    total++;
    if (err_udf !== 1'b1 || count !== 5'd0) begin
      bad++; $display("FAIL udf_flag err_udf=%b count=%0d exp 1/0", err_udf, count);
    end
    step();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
      bad++; $display("FAIL udf_read rd_valid=%b rd_data=%h exp 1/00000000", rd_valid, rd_data);
    end
    f = {$urandom, $urandom, $urandom, $urandom};
    flit = f; flit_valid = 1;
    step();
    flit_valid = 0; rd_en = 1; rd_word = 2'(1);
    step();
    rd_en = 0;
    step();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== f[63:32]) begin
      bad++; $display("FAIL udf_ptr rd_valid=%b rd_data=%h exp 1/%h", rd_valid, rd_data, f[63:32]);
    end
    for (int i = 0; i < 3; i++) begin
      flit = {$urandom, $urandom, $urandom, $urandom}; flit_valid = 1; rd_en = 1; rd_word = 2'(3);
      step();
    end
    idle_inputs(); rst = 1;
    step();
    total++;
    if ({act_status, rd_data} !== {10'b0000000100, 32'h0}) begin
      bad++; $display("FAIL midreset got=%b/%h exp=%b/%h", act_status, rd_data, 10'b0000000100, 32'h0);
    end
    rst = 0; pulses = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (lcrd_v) pulses++;
      total++;
      if (act_status !== exp_status()) begin
        bad++; $display("FAIL midreset_reissue cycle=%0d got=%b exp=%b", k, act_status, exp_status());
      end
    end
    total++;
    if (pulses != CREDITS) begin
      bad++; $display("FAIL midreset_pulses got=%0d exp=%0d", pulses, CREDITS);
    end
  endtask

  initial begin
    test_reset();
    test_read_words();
    test_fill_credits();
    test_overflow();
    test_stream();
    test_underflow_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
